// File: rtl/serial_adder_sender.sv
// Parallel-to-serial front end for the serial adder stream: sends two W-bit operands
// LSB-first, one bit per valid beat, and reassembles the returned sum bits into a W-bit result.
module serial_adder_sender #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         ser_en,
    output logic         vld,
    output logic         a,
    output logic         b,
    output logic         last,
    input  logic         sum,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_sum
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   sha_q;
    logic [W-1:0]   shb_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    logic [W-1:0]   out_sum_q;
    logic           in_rdy_q;
    logic           out_vld_q;
    logic           beat;
    logic           is_last;

    assign beat    = (state_q == SEND) && ser_en;
    assign is_last = (cnt_q == CNT_LAST);

    // Sum bits enter at the MSB and drift down, so bit i settles at position i after W beats.
    always_comb begin
        acc_d        = acc_q >> 1;
        acc_d[W-1]   = sum;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sha_q     <= '0;
            shb_q     <= '0;
            acc_q     <= '0;
            out_sum_q <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        sha_q    <= in_a;
                        shb_q    <= in_b;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (beat) begin
                        sha_q <= sha_q >> 1;
                        shb_q <= shb_q >> 1;
                        acc_q <= acc_d;
                        if (is_last) begin
                            cnt_q     <= '0;
                            out_sum_q <= acc_d;
                            out_vld_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_rdy_q  <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_rdy  = in_rdy_q;
    assign vld     = beat;
    assign a       = sha_q[0];
    assign b       = shb_q[0];
    assign last    = beat && is_last;
    assign out_vld = out_vld_q;
    assign out_sum = out_sum_q;

endmodule
